// File: rtl/rss_accum.sv
// Root-sum-of-squares accumulator.
// Each accepted sample a adds a*a to an accumulator (or restarts it when clear=1).
// A restoring square-root engine then computes g = floor(sqrt(acc)), one root bit per
// cycle. The result is held with a valid/ready handshake.
// Optional feature: define RSS_ACCUM_SAT_EN for a saturating accumulator with a sticky
// overflow flag. Without it, the accumulator wraps and overflow reads 0.
module rss_accum #(
   parameter int unsigned IN_W   = 8,
   parameter int unsigned ACC_W  = 20,
   localparam int unsigned ROOT_W = ACC_W / 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IN_W-1:0]   a,
   input  logic              valid_in,
   input  logic              clear,
   output logic              ready_in,
   output logic [ROOT_W-1:0] g,
   output logic              valid_out,
   input  logic              ready_out,
   output logic              overflow
);

   localparam int unsigned CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
   localparam int unsigned REM_W = ROOT_W + 2;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic [ACC_W-1:0]    rad_q, rad_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [ROOT_W-1:0]   root_q, root_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROOT_W-1:0]   g_q, g_d;
   logic                valid_q, valid_d;

   logic [2*IN_W-1:0]   sq;
   logic [ACC_W-1:0]    acc_new;
   logic                ovf_new;
   logic [REM_W-1:0]    rem_sh;
   logic [REM_W-1:0]    trial;
   logic                rem_ge;
   logic [ROOT_W-1:0]   root_step;

   assign sq = (2*IN_W)'(a) * (2*IN_W)'(a);

`ifdef RSS_ACCUM_SAT_EN
   logic [ACC_W:0] sum_ext;
   assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(sq);

   // Accumulator update: restart on clear, otherwise add and clamp at full scale.
   always_comb begin
      acc_new = acc_q;
      ovf_new = ovf_q;
      if (clear) begin
         // a*a alone always fits, so a clear handshake also drops the sticky flag
         acc_new = ACC_W'(sq);
         ovf_new = 1'b0;
      end else if (sum_ext[ACC_W]) begin
         acc_new = '1;
         ovf_new = 1'b1;
      end else begin
         acc_new = sum_ext[ACC_W-1:0];
      end
   end
`else
   logic [ACC_W-1:0] sum_wrap;
   assign sum_wrap = acc_q + ACC_W'(sq);

   // Accumulator update: restart on clear, otherwise add modulo 2^ACC_W.
   always_comb begin
      acc_new = clear ? ACC_W'(sq) : sum_wrap;
      ovf_new = 1'b0;
   end
`endif

   // One restoring square-root step: bring down the next two radicand bits, try 4*root+1.
   always_comb begin
      rem_sh    = (rem_q << 2) | REM_W'(rad_q[ACC_W-1 -: 2]);
      trial     = {root_q, 2'b01};
      rem_ge    = (rem_sh >= trial);
      root_step = {root_q[ROOT_W-2:0], rem_ge};
   end

   // FSM next state and datapath loads.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      rad_d   = rad_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      g_d     = g_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (valid_in) begin
               acc_d   = acc_new;
               ovf_d   = ovf_new;
               rad_d   = acc_new;
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = CNT_W'(ROOT_W - 1);
               state_d = StCalc;
            end
         end
         StCalc: begin
            rad_d  = rad_q << 2;
            rem_d  = rem_ge ? (rem_sh - trial) : rem_sh;
            root_d = root_step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = '0;
               g_d     = root_step;
               valid_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (ready_out) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         cnt_q   <= '0;
         g_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         cnt_q   <= cnt_d;
         g_q     <= g_d;
         valid_q <= valid_d;
      end
   end

   assign ready_in  = (state_q == StIdle);
   assign g         = g_q;
   assign valid_out = valid_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_rss_accum.sv
// Scoreboard bench for rss_accum at default parameters.
// The driver pushes hand-computed results into a queue. A negedge monitor pops an entry
// and compares it whenever a result is transferred. The monitor also checks the
// handshake-to-valid latency and the single-cycle valid pulse.
module tb_rss_accum;

   localparam int unsigned IN_W   = 8;
   localparam int unsigned ACC_W  = 20;
   localparam int unsigned ROOT_W = ACC_W / 2;
`ifdef RSS_ACCUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic [IN_W-1:0]   a;
   logic              valid_in;
   logic              clear;
   logic              ready_in;
   logic [ROOT_W-1:0] g;
   logic              valid_out;
   logic              ready_out;
   logic              overflow;

   rss_accum #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .valid_in  (valid_in),
      .clear     (clear),
      .ready_in  (ready_in),
      .g         (g),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ROOT_W-1:0] g;
      logic              ovf;
      bit                chk_g;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned hs_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired or missing event (t=%0t)", name, $time);
   endtask

   task automatic push(input logic [ROOT_W-1:0] gv, input logic ov, input bit chk);
      exp_t e;
      e.g     = gv;
      e.ovf   = ov;
      e.chk_g = chk;
      exp_q.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IN_W-1:0] av, input logic cl);
      int k = 0;
      while (!ready_in && k < 50) begin
         tick();
         k++;
      end
      if (!ready_in) fail_now("send_ready_timeout");
      valid_in = 1'b1;
      a        = av;
      clear    = cl;
      tick();
      valid_in = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!ready_in && k < 60) begin
         tick();
         k++;
      end
      if (!ready_in) fail_now("idle_timeout");
   endtask

   // Monitor: samples on the falling edge, away from input changes and the active edge.
   initial begin
      logic        vprev;
      logic        rprev;
      int unsigned hs;
      exp_t        e;
      vprev = 1'b0;
      rprev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            hs_q.delete();
            vprev = 1'b0;
            rprev = 1'b0;
         end else begin
            if (valid_in && ready_in) hs_q.push_back(cyc + 1);
            if (valid_out && !vprev) begin
               if (hs_q.size() == 0) fail_now("valid_without_handshake");
               else begin
                  hs = hs_q.pop_front();
                  check("latency", cyc - hs, ROOT_W);
               end
            end
            if (vprev && rprev) check("valid_pulse_len", {31'd0, valid_out}, 0);
            if (valid_out && ready_out) begin
               if (exp_q.size() == 0) fail_now("unexpected_result");
               else begin
                  e = exp_q.pop_front();
                  if (e.chk_g) check("g", {22'd0, g}, {22'd0, e.g});
                  check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
               end
            end
            vprev = valid_out;
            rprev = ready_out;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int k;
      valid_in  = 1'b0;
      a         = '0;
      clear     = 1'b0;
      ready_out = 1'b1;
      reset     = 1'b0;
      #12;
      check("rst_g", {22'd0, g}, 0);
      check("rst_valid_out", {31'd0, valid_out}, 0);
      check("rst_ready_in", {31'd0, ready_in}, 1);
      check("rst_overflow", {31'd0, overflow}, 0);
      tick();
      reset = 1'b1;
      tick();

      // Basic accumulation: 441 -> 21, 1737 -> 41, 5833 -> 76.
      push(10'd21, 1'b0, 1'b1); send(8'd21, 1'b1); wait_idle();
      push(10'd41, 1'b0, 1'b1); send(8'd36, 1'b0); wait_idle();
      push(10'd76, 1'b0, 1'b1); send(8'd64, 1'b0); wait_idle();

      // Clear restarts the accumulation: 9 -> 3.
      push(10'd3, 1'b0, 1'b1); send(8'd3, 1'b1); wait_idle();

      // Downstream stall: the result holds while ready_out is low.
      ready_out = 1'b0;
      push(10'd21, 1'b0, 1'b1);
      send(8'd21, 1'b1);
      k = 0;
      while (!valid_out && k < 30) begin
         tick();
         k++;
      end
      if (!valid_out) fail_now("stall_valid_timeout");
      repeat (5) begin
         check("stall_g", {22'd0, g}, 21);
         check("stall_valid", {31'd0, valid_out}, 1);
         check("stall_ready_in", {31'd0, ready_in}, 0);
         tick();
      end
      ready_out = 1'b1;
      tick();
      check("release_ready_in", {31'd0, ready_in}, 1);
      check("release_valid", {31'd0, valid_out}, 0);
      check("g_retained", {22'd0, g}, 21);

      // valid_in held high, a = i+1 each cycle: only IDLE edges (i = 0, 12, 24) are taken.
      // 1 -> 1, 1+169 = 170 -> 13, 170+625 = 795 -> 28.
      push(10'd1, 1'b0, 1'b1);
      push(10'd13, 1'b0, 1'b1);
      push(10'd28, 1'b0, 1'b1);
      for (int i = 0; i < 36; i++) begin
         valid_in = 1'b1;
         a        = IN_W'(i + 1);
         clear    = (i == 0);
         tick();
      end
      valid_in = 1'b0;
      clear    = 1'b0;
      wait_idle();

      // 17 x 255^2 = 1105425: saturates to 1023, or wraps to 56849 -> 238.
      for (int n = 1; n <= 17; n++) begin
         if (n == 17) push(SAT ? 10'd1023 : 10'd238, SAT, 1'b1);
         else push(10'd0, 1'b0, 1'b0);
         send(8'd255, (n == 1));
         wait_idle();
      end
      check("overflow_after_17", {31'd0, overflow}, {31'd0, SAT});

      // Reset mid-CALC aborts with no result; the accumulator restarts from 0.
      send(8'd9, 1'b1);
      repeat (4) tick();
      reset = 1'b0;
      #1;
      check("abort_valid", {31'd0, valid_out}, 0);
      check("abort_g", {22'd0, g}, 0);
      check("abort_ready_in", {31'd0, ready_in}, 1);
      check("abort_overflow", {31'd0, overflow}, 0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("post_abort_valid", {31'd0, valid_out}, 0);
      push(10'd5, 1'b0, 1'b1);
      send(8'd5, 1'b0);
      wait_idle();

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rss_accum.md
RSS_ACCUM -- requirements
Module: rss_accum

Interface
REQ-001 Parameter IN_W, default 8: unsigned sample width.
REQ-002 Parameter ACC_W, default 20: accumulator width; SHALL be even and >= 2*IN_W; ROOT_W = ACC_W/2.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low (asserted at 0).
REQ-005 a  input  IN_W  unsigned sample.
REQ-006 valid_in  input  1  sample valid.
REQ-007 clear  input  1  with an accepted sample, restarts the accumulation from that sample.
REQ-008 ready_in  output  1  block can accept a sample.
REQ-009 g  output  ROOT_W  floor(sqrt(accumulator)).
REQ-010 valid_out  output  1  g valid.
REQ-011 ready_out  input  1  downstream accepts g.
REQ-012 overflow  output  1  accumulator overflow flag (see Configuration).

Function
REQ-013 An input handshake SHALL occur on a rising edge where valid_in=1 and ready_in=1; a is ignored otherwise.
REQ-014 FSM states IDLE, CALC, DONE; ready_in SHALL equal (state==IDLE), combinationally from the state register.
REQ-015 On an input handshake: acc <= acc + a*a, or acc <= a*a if clear=1; a*a is 2*IN_W bits zero-extended to ACC_W; clear=0 with no handshake has no effect.
REQ-016 The same edge SHALL load the updated acc into an iterative restoring square-root engine and go IDLE->CALC with iteration counter = ROOT_W-1.
REQ-017 CALC SHALL resolve one root bit per edge, MSB first; after exactly ROOT_W CALC edges go CALC->DONE, registering g and valid_out=1.
REQ-018 Latency: handshake on edge N -> valid_out=1 and g valid after edge N+ROOT_W (10 cycles at defaults).
REQ-019 DONE: g and valid_out SHALL hold stable while ready_out=0; on an edge with ready_out=1, go DONE->IDLE and set valid_out=0.
REQ-020 g SHALL retain its last value after valid_out falls.
REQ-021 No input is accepted in CALC or DONE; minimum sample spacing is ROOT_W+2 cycles.
REQ-022 acc persists across results until a clear handshake or reset.

Reset
REQ-023 While reset=0, regardless of clk: state=IDLE, acc=0, g=0, valid_out=0, overflow=0, counter=0, root engine registers=0; ready_in therefore reads 1.
REQ-024 Reset asserted mid-CALC or mid-DONE SHALL abort the operation with no output produced; first handshake is possible on the first rising edge after reset rises.

Configuration
REQ-025 Macro RSS_ACCUM_SAT_EN defined: if acc + a*a exceeds 2^ACC_W-1, acc SHALL saturate to 2^ACC_W-1; overflow SHALL set on that edge and stay set (sticky) until a clear handshake with no overflow, or reset.
REQ-026 RSS_ACCUM_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; overflow SHALL be tied to 0; port list unchanged.

Verification (defaults IN_W=8, ACC_W=20)
REQ-027 Reset, then handshakes a=21 (clear=1), a=36, a=64, each after the previous result completes, ready_out=1 -> g=21, 41, 76 in order, each valid_out exactly 10 cycles after its handshake and high for 1 cycle.
REQ-028 a=21 with clear=1 and ready_out=0 for 5 cycles after valid_out rises -> g=21 and valid_out=1 held stable; ready_in=0 throughout; IDLE on the edge after ready_out=1.
REQ-029 After g=76 accumulation, a=3 with clear=1 -> g=3.
REQ-030 17 handshakes of a=255 (first with clear=1) -> with RSS_ACCUM_SAT_EN: final g=1023 and overflow=1 from the 17th result onward; without: final g=238, overflow=0.
REQ-031 reset driven low 4 cycles into CALC, then released -> valid_out stays 0, g=0, ready_in=1; next a=5 with clear=0 -> g=5.
REQ-032 valid_in=1 held continuously with changing a -> only the samples present on IDLE edges are accumulated; results match a software model of those samples.
